// File: rtl/instr_stream_gen.sv
`timescale 1ns/1ps
// instr_stream_gen: seedable RV32 random instruction stream generator.
// Latency: a start sampled at edge t shows its first bundle in cycle t+1, then
//   one bundle per accepted handshake (ISSUE_WIDTH instructions per cycle).
// Backpressure: while out_valid && !out_ready the bundle, lane_valid and all
//   lane LFSRs hold. out_valid depends on registered state only.
//
// Ports:
//   clk           rising-edge clock for all state
//   reset         synchronous, active-high
//   start         begin a run (sampled only in IDLE)
//   num_instr     instruction count, sampled with start
//   out_valid     bundle valid (state RUN)
//   out_ready     consumer accepts the current bundle
//   instr_out     lane i at bits [32i+31:32i]
//   lane_valid    per-lane valid; the final bundle may be partial
//   busy          state is RUN
//   done          one-cycle pulse after the final handshake
//   issued_count  instructions accepted in the current/last run
//
// Optional build macro ISG_HAZARD_EN: for lanes i>0, when the lane's hash bit
//   (r[0]^r[8]^r[16]^r[24]) is set and lane i-1 is valid, rs1 is forced to
//   lane i-1's rd, injecting intra-bundle RAW hazards. Undefined by default.

module instr_stream_gen #(
  parameter int          ISSUE_WIDTH = 2,
  parameter int          CNT_W       = 16,
  parameter logic [31:0] SEED        = 32'hACE1_2468,
  parameter int          TH_LOAD     = 26,
  parameter int          TH_STORE    = 51,
  parameter int          TH_JAL      = 77,
  parameter int          TH_BR       = 154,
  parameter int          TH_IIMM     = 205
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [32*ISSUE_WIDTH-1:0] instr_out,
  output logic [ISSUE_WIDTH-1:0]   lane_valid,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         issued_count
);

  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Galois LFSR feedback taps (shift right)
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  // Per-lane seed spreading constant (golden-ratio increment)
  localparam logic [31:0] LANE_SPREAD = 32'h9E37_79B9;

  localparam logic [CNT_W-1:0] IW_CNT = CNT_W'(ISSUE_WIDTH);

  // RV32 major opcodes
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_IIMM  = 7'b0010011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  logic [1:0]       state;
  logic [CNT_W-1:0] remaining;
  logic [31:0]      lfsr [ISSUE_WIDTH];

  // Instructions in the current bundle. In RUN this equals popcount(lane_valid),
  // since lane_valid is a thermometer code of min(remaining, ISSUE_WIDTH).
  logic [CNT_W-1:0] take;
  logic             fire;

  function automatic logic [31:0] lane_seed(input int lane);
    logic [31:0] s;
    s = SEED ^ (32'(lane) * LANE_SPREAD);
    // An all-zero Galois LFSR never leaves zero
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] r);
    return r[0] ? ((r >> 1) ^ LFSR_TAPS) : (r >> 1);
  endfunction

  assign take = (remaining < IW_CNT) ? remaining : IW_CNT;
  assign fire = (state == S_RUN) && out_ready;

  // ---------------------------------------------------------------------------
  // Control and LFSR state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      remaining    <= '0;
      issued_count <= '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        lfsr[i] <= lane_seed(i);
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (num_instr != '0) begin
              state        <= S_RUN;
              remaining    <= num_instr;
              issued_count <= '0;
              // Reload so every run replays the same deterministic sequence
              for (int i = 0; i < ISSUE_WIDTH; i++) begin
                lfsr[i] <= lane_seed(i);
              end
            end else begin
              state <= S_DONE;
            end
          end
        end

        S_RUN: begin
          if (fire) begin
            issued_count <= issued_count + take;
            remaining    <= remaining - take;
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
              lfsr[i] <= lfsr_step(lfsr[i]);
            end
            if (remaining == take) begin
              state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  assign out_valid = (state == S_RUN);
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);

  // ---------------------------------------------------------------------------
  // Per-lane instruction encoding
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_lane
    logic [31:0] r;
    logic [7:0]  sel;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [6:0]  opcode;

    assign r = lfsr[i];

    // Thermometer valid: lane i carries an instruction while i < remaining
    assign lane_valid[i] = (state == S_RUN) && (remaining > CNT_W'(i));

    assign sel    = r[7:0];
    assign rd     = r[12:8];
    assign rs2    = r[22:18];
    assign funct3 = r[25:23];

`ifdef ISG_HAZARD_EN
    if (i > 0) begin : g_hazard
      logic hash;
      assign hash = r[0] ^ r[8] ^ r[16] ^ r[24];
      assign rs1  = (hash && lane_valid[i-1]) ? lfsr[i-1][12:8] : r[17:13];
    end else begin : g_no_hazard
      assign rs1 = r[17:13];
    end
`else
    assign rs1 = r[17:13];
`endif

    // Weighted opcode mix from cumulative thresholds out of 256
    always_comb begin
      opcode = OP_RTYPE;
      if (32'(sel) < TH_LOAD) begin
        opcode = OP_LOAD;
      end else if (32'(sel) < TH_STORE) begin
        opcode = OP_STORE;
      end else if (32'(sel) < TH_JAL) begin
        opcode = OP_JAL;
      end else if (32'(sel) < TH_BR) begin
        opcode = OP_BR;
      end else if (32'(sel) < TH_IIMM) begin
        opcode = OP_IIMM;
      end
    end

    // ADD/SUB, SRL/SRA and SRLI/SRAI only have legal funct7 of 0 or 32
    always_comb begin
      funct7 = {r[31:26], r[0]};
      if (((opcode == OP_RTYPE) && ((funct3 == 3'd0) || (funct3 == 3'd5))) ||
          ((opcode == OP_IIMM) && (funct3 == 3'd5))) begin
        funct7 = r[26] ? 7'd32 : 7'd0;
      end
    end

    // Same field layout for every opcode; unused fields simply carry noise
    assign instr_out[32*i +: 32] = {funct7, rs2, rs1, funct3, rd, opcode};
  end

endmodule

// File: tb/tb_instr_stream_gen.sv
`timescale 1ns/1ps
// Testbench for instr_stream_gen: directed runs checked against a reference
// LFSR/encoder model through an expected-bundle queue.

module tb_instr_stream_gen;

  localparam int          IW   = 2;
  localparam int          CW   = 16;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic              clk;
  logic              reset;
  logic              start;
  logic [CW-1:0]     num_instr;
  logic              out_valid;
  logic              out_ready;
  logic [32*IW-1:0]  instr_out;
  logic [IW-1:0]     lane_valid;
  logic              busy;
  logic              done;
  logic [CW-1:0]     issued_count;

  instr_stream_gen #(
    .ISSUE_WIDTH(IW),
    .CNT_W      (CW),
    .SEED       (SEED)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_instr   (num_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .instr_out   (instr_out),
    .lane_valid  (lane_valid),
    .busy        (busy),
    .done        (done),
    .issued_count(issued_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [32*IW-1:0] instr;
    logic [IW-1:0]    lv;
  } bundle_t;

  bundle_t sb[$];
  int      checks = 0;
  int      errors = 0;
  int      hist[6];
  int      f7_bad;
  bit      hist_en = 1'b0;

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_step(input logic [31:0] r);
    logic [31:0] n;
    n = r >> 1;
    if (r[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  function automatic logic [31:0] m_seed(input int lane);
    logic [31:0] k;
    logic [31:0] s;
    k = 32'h9E37_79B9;
    s = SEED ^ (k * 32'(lane));
    if (s == 32'h0) s = 32'h1;
    return s;
  endfunction

  function automatic logic [31:0] m_encode(input logic [31:0] r);
    int         sel;
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    sel = int'(r[7:0]);
    f3  = r[25:23];
    f7  = {r[31:26], r[0]};
    if (sel < 26)       op = 7'b0000011;
    else if (sel < 51)  op = 7'b0100011;
    else if (sel < 77)  op = 7'b1101111;
    else if (sel < 154) op = 7'b1100011;
    else if (sel < 205) op = 7'b0010011;
    else                op = 7'b0110011;
    if ((op == 7'b0110011 && (f3 == 3'd0 || f3 == 3'd5)) ||
        (op == 7'b0010011 && f3 == 3'd5))
      f7 = r[26] ? 7'd32 : 7'd0;
    return {f7, r[22:18], r[17:13], f3, r[12:8], op};
  endfunction

  // Push every bundle a run of n instructions should produce
  task automatic push_run(input int n);
    logic [31:0] st [IW];
    bundle_t     b;
    int          rem;
    for (int i = 0; i < IW; i++) st[i] = m_seed(i);
    rem = n;
    while (rem > 0) begin
      for (int i = 0; i < IW; i++) begin
        b.instr[32*i +: 32] = m_encode(st[i]);
        b.lv[i]             = (i < rem);
      end
      sb.push_back(b);
      rem = rem - ((rem < IW) ? rem : IW);
      for (int i = 0; i < IW; i++) st[i] = m_step(st[i]);
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tally(input logic [32*IW-1:0] w, input logic [IW-1:0] lv);
    logic [31:0] x;
    for (int i = 0; i < IW; i++) begin
      if (lv[i]) begin
        x = w[32*i +: 32];
        case (x[6:0])
          7'b0000011: hist[0]++;
          7'b0100011: hist[1]++;
          7'b1101111: hist[2]++;
          7'b1100011: hist[3]++;
          7'b0010011: hist[4]++;
          7'b0110011: hist[5]++;
          default: ;
        endcase
        if (((x[6:0] == 7'b0110011) && (x[14:12] == 3'd0 || x[14:12] == 3'd5)) ||
            ((x[6:0] == 7'b0010011) && (x[14:12] == 3'd5))) begin
          if (x[31:25] != 7'd0 && x[31:25] != 7'd32) f7_bad++;
        end
      end
    end
  endtask

  // Drive start so that it is sampled at the next rising edge (edge t)
  task automatic kick(input int n);
    @(posedge clk);
    #1;
    num_instr = CW'(n);
    start     = 1'b1;
  endtask

  // Cycle c of the loop is cycle t+c; out_ready is low for c in [s0, s1]
  task automatic consume(input int budget, input int s0, input int s1, output int done_c);
    done_c = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      start     = 1'b0;
      out_ready = !(c >= s0 && c <= s1);
      @(negedge clk);
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_bundle", 64'(out_valid), 64'd0);
        end else begin
          check("instr_out", 64'(instr_out), 64'(sb[0].instr));
          check("lane_valid", 64'(lane_valid), 64'(sb[0].lv));
          check("busy_in_run", 64'(busy), 64'd1);
          if (out_ready) begin
            if (hist_en) tally(instr_out, lane_valid);
            void'(sb.pop_front());
          end
        end
      end
      if (done) begin
        done_c = c;
        check("out_valid_at_done", 64'(out_valid), 64'd0);
        check("busy_at_done", 64'(busy), 64'd0);
        break;
      end
    end
    if (done_c < 0) check("done_timeout", 64'd0, 64'd1);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int          dc;
    logic [63:0] exp_seed_word;
    int          exp_cnt[6];
    int          diff;

    reset     = 1'b1;
    start     = 1'b0;
    num_instr = '0;
    out_ready = 1'b1;
    f7_bad    = 0;
    for (int k = 0; k < 6; k++) hist[k] = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset / idle state
    for (int i = 0; i < IW; i++) exp_seed_word[32*i +: 32] = m_encode(m_seed(i));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("idle_out_valid", 64'(out_valid), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_done", 64'(done), 64'd0);
      check("idle_issued", 64'(issued_count), 64'd0);
      check("idle_lane_valid", 64'(lane_valid), 64'd0);
    end
    check("reset_instr_out", 64'(instr_out), exp_seed_word);

    // Unstalled run of 5: bundles 11,11,01 at t+1..t+3, done at t+4
    push_run(5);
    kick(5);
    consume(20, 0, -1, dc);
    check("run5_done_cycle", 64'(dc), 64'd4);
    check("run5_issued", 64'(issued_count), 64'd5);

    // Same run with out_ready low in cycles t+2..t+4: three extra cycles
    push_run(5);
    kick(5);
    consume(20, 2, 4, dc);
    check("stall_done_cycle", 64'(dc), 64'd7);
    check("stall_issued", 64'(issued_count), 64'd5);

    // num_instr = 0: immediate done pulse
    kick(0);
    consume(5, 0, -1, dc);
    check("zero_done_cycle", 64'(dc), 64'd1);

    // Reset in the middle of a run: no done pulse, state cleared
    kick(5);
    @(posedge clk);                 // edge t
    #1 start = 1'b0;
    @(posedge clk);                 // edge t+1: first handshake
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'd0);
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_issued", 64'(issued_count), 64'd0);
    end
    check("abort_instr_at_seed", 64'(instr_out), exp_seed_word);

    // Restart replays the identical sequence
    push_run(5);
    kick(5);
    consume(20, 0, -1, dc);
    check("replay_done_cycle", 64'(dc), 64'd4);
    check("replay_issued", 64'(issued_count), 64'd5);

    // Long run: opcode mix and funct7 legality
    hist_en = 1'b1;
    push_run(10000);
    kick(10000);
    consume(5200, 0, -1, dc);
    hist_en = 1'b0;
    check("long_done_cycle", 64'(dc), 64'd5001);
    check("long_issued", 64'(issued_count), 64'd10000);
    check("funct7_illegal", 64'(f7_bad), 64'd0);
    exp_cnt[0] = 1000; exp_cnt[1] = 1000; exp_cnt[2] = 1000;
    exp_cnt[3] = 3000; exp_cnt[4] = 2000; exp_cnt[5] = 2000;
    for (int k = 0; k < 6; k++) begin
      diff = hist[k] - exp_cnt[k];
      if (diff < 0) diff = -diff;
      checks++;
      assert (diff <= 200)
      else begin
        errors++;
        $error("FAIL hist_%0d: observed %0d expected %0d +/-200", k, hist[k], exp_cnt[k]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
